// File: rtl/expr_pkg.sv
// Shared constants and types for the expression generator and recognizer.
package expr_pkg;

  localparam int unsigned MAX_TERMS_DEF = 8;

  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_STAR = 8'h2A;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIGIT = 2'd1,
    OP    = 2'd2
  } state_t;

endpackage

// File: rtl/expr_char_enc.sv
// Maps a digit or an operator bit to its ASCII character.
module expr_char_enc
  import expr_pkg::*;
(
  input  logic       i_is_op,
  input  logic [3:0] i_digit,
  input  logic       i_op_bit,
  output logic [7:0] o_char
);

  // Pure combinational encoding.
  always_comb begin
    if (i_is_op) begin
      o_char = (i_op_bit == OP_MUL) ? CH_STAR : CH_PLUS;
    end else begin
      o_char = CH_ZERO + {4'h0, i_digit};
    end
  end

endmodule

// File: rtl/expr_gen.sv
// Emits one arithmetic expression (digit (op digit)*) as an ASCII character
// stream over a valid/ready handshake. All outputs are registered.
module expr_gen
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = MAX_TERMS_DEF
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [3:0]             n_terms,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [7:0]             out_char,
  output logic                   out_last,
  output logic                   busy,
  output logic                   err
);

  localparam int unsigned IW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IW-1:0]        r_idx;
  logic [IW-1:0]        w_idx_nxt;
  logic [IW-1:0]        w_idx_inc;
  logic [IW-1:0]        w_last_idx;
  logic [3:0]           r_n;
  logic [3:0]           r_dig [MAX_TERMS];
  logic [MAX_TERMS-2:0] r_ops;

  logic                 r_valid;
  logic                 r_last;
  logic                 r_busy;
  logic                 r_err;
  logic [7:0]           r_char;
  logic                 w_valid_nxt;
  logic                 w_last_nxt;
  logic                 w_busy_nxt;
  logic                 w_err_nxt;
  logic [7:0]           w_char_nxt;

  logic                 w_load;
  logic                 w_legal;
  logic                 w_xfer;
  logic                 w_enc_is_op;
  logic [3:0]           w_enc_digit;
  logic                 w_enc_op;
  logic [7:0]           w_enc_char;

  assign out_valid  = r_valid;
  assign out_char   = r_char;
  assign out_last   = r_last;
  assign busy       = r_busy;
  assign err        = r_err;

  assign w_xfer     = r_valid & out_ready;
  assign w_idx_inc  = r_idx + IW'(1);
  assign w_last_idx = IW'(r_n - 4'd1);

  // Request legality: count in range and every used term a BCD digit.
  always_comb begin
    w_legal = (n_terms != 4'd0) && (32'(n_terms) <= MAX_TERMS);
    for (int unsigned i = 0; i < MAX_TERMS; i++) begin
      if ((i < 32'(n_terms)) && (digits[4*i +: 4] > 4'd9)) begin
        w_legal = 1'b0;
      end
    end
  end

  expr_char_enc u_enc (
    .i_is_op  (w_enc_is_op),
    .i_digit  (w_enc_digit),
    .i_op_bit (w_enc_op),
    .o_char   (w_enc_char)
  );

  // Next-state logic; the character for the next state is encoded here so
  // that out_char is registered alongside the state change.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_last_nxt  = r_last;
    w_busy_nxt  = r_busy;
    w_char_nxt  = r_char;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    w_enc_is_op = 1'b0;
    w_enc_digit = 4'd0;
    w_enc_op    = OP_ADD;

    unique case (r_state)
      IDLE: begin
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        if (start) begin
          if (w_legal) begin
            // First digit comes straight from the inputs being latched.
            w_load      = 1'b1;
            w_state_nxt = DIGIT;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b1;
            w_busy_nxt  = 1'b1;
            w_enc_digit = digits[3:0];
            w_char_nxt  = w_enc_char;
            w_last_nxt  = (n_terms == 4'd1);
          end else begin
            w_err_nxt   = 1'b1;
          end
        end
      end

      DIGIT: begin
        if (w_xfer) begin
          if (r_idx == w_last_idx) begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = OP;
            w_enc_is_op = 1'b1;
            w_enc_op    = r_ops[r_idx];
            w_char_nxt  = w_enc_char;
            w_last_nxt  = 1'b0;
          end
        end
      end

      OP: begin
        if (w_xfer) begin
          w_state_nxt = DIGIT;
          w_idx_nxt   = w_idx_inc;
          w_enc_digit = r_dig[w_idx_inc];
          w_char_nxt  = w_enc_char;
          w_last_nxt  = (w_idx_inc == w_last_idx);
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, index and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_char  <= 8'h00;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_char  <= w_char_nxt;
      r_last  <= w_last_nxt;
      r_busy  <= w_busy_nxt;
      r_err   <= w_err_nxt;
    end
  end

  // Operand capture on an accepted start; held for the whole stream.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_n   <= '0;
      r_ops <= '0;
      for (int unsigned i = 0; i < MAX_TERMS; i++) begin
        r_dig[i] <= '0;
      end
    end else if (w_load) begin
      r_n   <= n_terms;
      r_ops <= ops;
      for (int unsigned i = 0; i < MAX_TERMS; i++) begin
        r_dig[i] <= digits[4*i +: 4];
      end
    end
  end

endmodule

// File: tb/tb_expr_gen.sv
// Randomized self-checking bench for expr_gen with a string-level model.
module tb_expr_gen;
  import expr_pkg::*;

  localparam int unsigned MT = 8;

  logic            clk = 1'b0;
  logic            clr;
  logic            start;
  logic [3:0]      n_terms;
  logic [4*MT-1:0] digits;
  logic [MT-2:0]   ops;
  logic            out_ready;
  logic            out_valid;
  logic [7:0]      out_char;
  logic            out_last;
  logic            busy;
  logic            err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  expr_gen #(.MAX_TERMS(MT)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .n_terms   (n_terms),
    .digits    (digits),
    .ops       (ops),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_char  (out_char),
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_legal(input int n, input logic [4*MT-1:0] dg);
    if (n < 1 || n > int'(MT)) return 1'b0;
    for (int i = 0; i < n; i++)
      if (dg[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Requests one expression; mode 0 = ready always high, 1 = random ready,
  // 2 = ready follows pat for the first five cycles then stays high.
  task automatic send(input int n, input logic [4*MT-1:0] dg, input logic [MT-2:0] op,
                      input int mode, input logic [4:0] pat);
    byte unsigned q[$];
    int budget;
    int c;
    bit ok;
    ok = is_legal(n, dg);
    if (ok) begin
      for (int i = 0; i < n; i++) begin
        q.push_back(8'h30 + {4'h0, dg[4*i +: 4]});
        if (i < n - 1) q.push_back(op[i] ? 8'h2A : 8'h2B);
      end
    end
    n_terms   = 4'(n);
    digits    = dg;
    ops       = op;
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    start   = 1'b0;
    n_terms = 4'($urandom);
    digits  = {$urandom, $urandom};
    ops     = 7'($urandom);
    if (!ok) begin
      chk("rej_err", err, 1);
      chk("rej_valid", out_valid, 0);
      chk("rej_busy", busy, 0);
      tick();
      chk("rej_err_clear", err, 0);
      chk("rej_valid2", out_valid, 0);
      chk("rej_busy2", busy, 0);
      return;
    end
    chk("acc_err", err, 0);
    budget = 8 * n + 20;
    c = 0;
    while (q.size() > 0 && budget > 0) begin
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("char", out_char, q[0]);
      chk("last", out_last, (q.size() == 1) ? 1 : 0);
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = (c < 5) ? pat[c] : 1'b1;
      endcase
      if (out_ready) void'(q.pop_front());
      // Random start requests while busy must be ignored; never leave one
      // pending into the first idle cycle.
      start   = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      n_terms = 4'($urandom);
      tick();
      c++;
      budget--;
    end
    if (q.size() > 0) chk("timeout", q.size(), 0);
    start     = 1'b0;
    out_ready = 1'b1;
    chk("end_valid", out_valid, 0);
    chk("end_busy", busy, 0);
    chk("end_last", out_last, 0);
  endtask

  initial begin
    logic [4*MT-1:0] dg;
    logic [MT-2:0]   op;
    int              n;
    int              r;

    clr = 1'b0; start = 1'b0; out_ready = 1'b1;
    n_terms = '0; digits = '0; ops = '0;

    // Asynchronous reset, observed before any clock edge.
    #2 clr = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_char", out_char, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    tick();
    clr = 1'b0;
    tick();

    // 5,+,0,*,7 with no stalls.
    send(3, 32'h0000_0705, 7'b000_0010, 0, 5'b0);
    // Single digit.
    send(1, 32'h0000_0009, 7'b0, 0, 5'b0);
    // Stall pattern 1,0,0,1,1; unused terms hold non-BCD garbage.
    send(2, 32'hFFFF_FF38, 7'b111_1111, 2, 5'b11001);
    // Illegal: zero terms, then a non-BCD used term.
    send(0, 32'h0000_0012, 7'b0, 0, 5'b0);
    send(2, 32'h0000_00A4, 7'b0, 0, 5'b0);
    send(9, 32'h1111_1111, 7'b0, 0, 5'b0);

    // Abort mid-stream after two transfers of a five-character expression.
    n_terms = 4'd3; digits = 32'h0000_0123; ops = 7'b0; out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_char", out_char, 0);
    chk("abort_last", out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_err", err, 0);
    #2 clr = 1'b0;
    tick();
    chk("post_abort_valid", out_valid, 0);
    tick();
    chk("post_abort_valid2", out_valid, 0);
    chk("post_abort_busy", busy, 0);
    send(3, 32'h0000_0864, 7'b000_0001, 0, 5'b0);

    // Randomized requests, including occasional illegal ones.
    for (int k = 0; k < 60; k++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)      n = 0;
      else if (r == 1) n = int'($urandom_range(9, 15));
      else             n = int'($urandom_range(1, MT));
      for (int i = 0; i < int'(MT); i++) dg[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) dg[4*$urandom_range(0, MT-1) +: 4] = 4'($urandom_range(10, 15));
      op = 7'($urandom);
      send(n, dg, op, int'($urandom_range(0, 1)), 5'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/expr_gen.md
EXPR_GEN -- requirements
Module: expr_gen

Interface
REQ-001 Parameter MAX_TERMS, default 8: maximum number of operands per expression.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 clr  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request to emit one expression; sampled only in IDLE.
REQ-005 n_terms  input  4  operand count, legal range 1..MAX_TERMS.
REQ-006 digits  input  4*MAX_TERMS  BCD operands; term i in bits [4i+3:4i].
REQ-007 ops  input  MAX_TERMS-1  operators; bit i sits between term i and term i+1; 0 = '+', 1 = '*'.
REQ-008 out_ready  input  1  downstream consumer accepts out_char this cycle.
REQ-009 out_valid  output  1  out_char holds a valid character.
REQ-010 out_char  output  8  ASCII character.
REQ-011 out_last  output  1  high with the final character of an expression.
REQ-012 busy  output  1  high from an accepted start until the last character is transferred.
REQ-013 err  output  1  one-cycle pulse when a start request is rejected.

Function
REQ-014 The FSM SHALL have three states:
- IDLE
- DIGIT: presenting term idx.
- OP: presenting operator idx.
REQ-015 In IDLE with start=1 and legal inputs, the block SHALL latch n_terms, digits and ops, set idx=0 and busy=1, and enter DIGIT on that edge.
- out_valid is high in the next cycle.
REQ-016 Inputs are illegal when n_terms=0, n_terms>MAX_TERMS, or any digit among terms 0..n_terms-1 exceeds 9.
- The block SHALL stay in IDLE, emit no characters, and pulse err for exactly one cycle.
REQ-017 Character encoding:
- digit d -> 8'h30+d
- '+' -> 8'h2B
- '*' -> 8'h2A
REQ-018 A transfer occurs only on an edge where out_valid=1 and out_ready=1.
- While out_valid=1 and out_ready=0, out_char and out_last SHALL hold stable.
REQ-019 DIGIT transfer with idx<n_terms-1 -> OP (same idx).
REQ-020 OP transfer -> DIGIT with idx+1.
REQ-021 DIGIT transfer with idx=n_terms-1 -> IDLE.
- out_last=1 during that character.
- out_valid and busy SHALL be 0 in the following cycle.
REQ-022 Each expression SHALL consist of exactly 2*n_terms-1 characters, alternating digit/operator, starting and ending with a digit.
- Every emitted stream is therefore a legal digit(op digit)* string.
REQ-023 start SHALL be ignored while busy=1; input changes after the start edge SHALL NOT affect the stream in progress.
REQ-024 With out_ready held high, the block SHALL emit one character per cycle with no bubbles.
- Earliest next start is accepted on the first cycle in IDLE, one cycle after the last transfer.
REQ-025 n_terms=1 SHALL produce a single digit character with out_last=1.
REQ-026 out_valid SHALL NOT depend combinationally on out_ready; all outputs are registered.

Reset
REQ-027 On clr=1, asynchronously and independent of clk, the block SHALL set:
- state = IDLE, idx = 0
- out_valid = 0, out_char = 8'h00
- out_last = 0, busy = 0, err = 0
REQ-028 A clr during a stream SHALL abort it; no further characters of that expression are emitted after clr deasserts.
REQ-029 After clr deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Structure
REQ-030 A shared package expr_pkg SHALL hold:
- ASCII constants CH_ZERO, CH_PLUS, CH_STAR
- operator encoding OP_ADD=0, OP_MUL=1
- state encoding IDLE/DIGIT/OP
- default MAX_TERMS
These are reused by the existing expression recognizer bench.
REQ-031 One combinational sub-module expr_char_enc SHALL map (is_op, digit, op_bit) to the 8-bit ASCII character.
REQ-032 Operand and operator selection SHALL be by idx indexing of the latched vectors; no shift-out destruction is needed.

Verification
REQ-033 n_terms=3, digits={..,7,0,5}, ops=2'b10, out_ready=1 -> chars 35,2B,30,2A,37 on 5 consecutive cycles; out_last only on 37; busy low next cycle.
REQ-034 n_terms=1, digit 9 -> single char 39 with out_last=1; err=0.
REQ-035 n_terms=2, out_ready toggled 1,0,0,1,1 -> out_char held during stalls; exactly 3 transfers; no duplicate or lost characters.
REQ-036 n_terms=0; then n_terms=2 with term1=4'hA -> err pulses one cycle each; out_valid stays 0; busy stays 0.
REQ-037 clr asserted mid-stream after 2 transfers of a 5-char expression -> outputs at reset values immediately; a new start after release emits a full new expression.
REQ-038 Loop every stream into the expression recognizer -> its out=1 after the last character of each stream; start pulses while busy=1 are ignored.
